// File: rtl/arb_fifo_bridge.sv
// Elastic buffer between the readout arbiter and the downstream transfer FIFO.
// Absorbs NEAR_FULL back-pressure with resume hysteresis and exports fill/traffic counters.
module arb_fifo_bridge #(
  parameter int ADDR_WIDTH    = 4,
  parameter int RESUME_CYCLES = 4
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  ARB_WRITE,
  input  logic [31:0]           ARB_DATA,
  output logic                  ARB_READY,
  output logic                  FIFO_WRITE,
  output logic [31:0]           FIFO_DATA,
  input  logic                  FIFO_FULL,
  input  logic                  FIFO_NEAR_FULL,
  input  logic                  CLEAR_COUNTERS,
  output logic [ADDR_WIDTH:0]   FILL_LEVEL,
  output logic [31:0]           WORD_COUNT,
  output logic [15:0]           HOLD_COUNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [7:0]       RESUME_C = 8'(RESUME_CYCLES - 1);

  // state | meaning
  // RUN   | pops allowed whenever buffer non-empty and downstream not full/near-full
  // HOLD  | pops blocked until NEAR_FULL stays low for RESUME_CYCLES cycles
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             run_cnt_q, run_cnt_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   arb_ready_q, arb_ready_d;
  logic                   fifo_write_q, fifo_write_d;
  logic [31:0]            fifo_data_q, fifo_data_d;
  logic [31:0]            word_count_q, word_count_d;
  logic [15:0]            hold_count_q, hold_count_d;
  logic [31:0]            mem_q [DEPTH];

  logic push, pop, non_empty;

  always_comb begin
    non_empty = (count_q != '0);
    push      = ARB_WRITE & arb_ready_q;
    pop       = non_empty & ~FIFO_FULL & ~FIFO_NEAR_FULL & (state_q == RUN);
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      RUN: begin
        run_cnt_d = '0;
        if (FIFO_NEAR_FULL) state_d = HOLD;
      end
      HOLD: begin
        if (FIFO_NEAR_FULL) begin
          run_cnt_d = '0;
        end else if (run_cnt_q >= RESUME_C) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = RUN;
        run_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    // Ready looks ahead at the next count so a registered ready can never overfill.
    arb_ready_d  = (count_d < DEPTH_C);
    fifo_write_d = pop;
    fifo_data_d  = pop ? mem_q[rd_ptr_q] : fifo_data_q;

    word_count_d = word_count_q;
    hold_count_d = hold_count_q;
    if (CLEAR_COUNTERS) begin
      word_count_d = '0;
      hold_count_d = '0;
    end else begin
      if (pop) word_count_d = word_count_q + 32'd1;
      if (non_empty && !pop && hold_count_q != 16'hFFFF) hold_count_d = hold_count_q + 16'd1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q      <= RUN;
      run_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      arb_ready_q  <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      word_count_q <= '0;
      hold_count_q <= '0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      arb_ready_q  <= arb_ready_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      word_count_q <= word_count_d;
      hold_count_q <= hold_count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge BUS_CLK) begin
    if (push && !BUS_RST) mem_q[wr_ptr_q] <= ARB_DATA;
  end

  assign ARB_READY  = arb_ready_q;
  assign FIFO_WRITE = fifo_write_q;
  assign FIFO_DATA  = fifo_data_q;
  assign FILL_LEVEL = count_q;
  assign WORD_COUNT = word_count_q;
  assign HOLD_COUNT = hold_count_q;

endmodule

// File: tb/tb_arb_fifo_bridge.sv
// Randomized and directed bench for arb_fifo_bridge against a queue-based reference model.
module tb_arb_fifo_bridge;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int RESUME = 4;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b1;
  logic          ARB_WRITE = 1'b0;
  logic [31:0]   ARB_DATA = '0;
  logic          ARB_READY;
  logic          FIFO_WRITE;
  logic [31:0]   FIFO_DATA;
  logic          FIFO_FULL = 1'b0;
  logic          FIFO_NEAR_FULL = 1'b0;
  logic          CLEAR_COUNTERS = 1'b0;
  logic [AW:0]   FILL_LEVEL;
  logic [31:0]   WORD_COUNT;
  logic [15:0]   HOLD_COUNT;

  arb_fifo_bridge #(.ADDR_WIDTH(AW), .RESUME_CYCLES(RESUME)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .ARB_WRITE(ARB_WRITE), .ARB_DATA(ARB_DATA), .ARB_READY(ARB_READY),
    .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA),
    .FIFO_FULL(FIFO_FULL), .FIFO_NEAR_FULL(FIFO_NEAR_FULL),
    .CLEAR_COUNTERS(CLEAR_COUNTERS), .FILL_LEVEL(FILL_LEVEL),
    .WORD_COUNT(WORD_COUNT), .HOLD_COUNT(HOLD_COUNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: words held, throttle status, expected registered outputs.
  logic [31:0] q_m[$];
  bit          hold_m   = 1'b0;
  int          quiet_m  = 0;
  bit          ready_m  = 1'b0;
  bit          wr_m     = 1'b0;
  logic [31:0] data_m   = '0;
  logic [31:0] wc_m     = '0;
  logic [15:0] hc_m     = '0;

  int  cyc = 0;
  bit  last_accept;
  int  first_acc = -1;
  int  first_wr  = -1;
  bit  check_data = 1'b1;

  task automatic tick();
    bit pop_m;
    int cur;
    cur = cyc;
    last_accept = 1'b0;
    if (BUS_RST) begin
      q_m.delete();
      hold_m = 0; quiet_m = 0; ready_m = 0; wr_m = 0;
      data_m = '0; wc_m = '0; hc_m = '0;
    end else begin
      last_accept = ARB_WRITE && ready_m;
      pop_m = (q_m.size() > 0) && !FIFO_FULL && !FIFO_NEAR_FULL && !hold_m;
      wr_m = pop_m;
      if (pop_m) data_m = q_m[0];
      if (CLEAR_COUNTERS) begin
        wc_m = '0; hc_m = '0;
      end else begin
        if (pop_m) wc_m = wc_m + 1;
        if (q_m.size() > 0 && !pop_m && hc_m != 16'hFFFF) hc_m = hc_m + 1;
      end
      if (FIFO_NEAR_FULL) begin
        hold_m = 1; quiet_m = 0;
      end else if (hold_m) begin
        quiet_m++;
        if (quiet_m >= RESUME) begin hold_m = 0; quiet_m = 0; end
      end
      if (pop_m) void'(q_m.pop_front());
      if (last_accept) q_m.push_back(ARB_DATA);
      ready_m = q_m.size() < DEPTH;
      if (last_accept && first_acc < 0) first_acc = cur;
    end
    @(posedge BUS_CLK);
    #1;
    cyc++;
    chk("arb_ready",  {31'd0, ARB_READY},  {31'd0, ready_m});
    chk("fifo_write", {31'd0, FIFO_WRITE}, {31'd0, wr_m});
    if (check_data) chk("fifo_data", FIFO_DATA, data_m);
    chk("fill_level", {27'd0, FILL_LEVEL}, q_m.size());
    chk("word_count", WORD_COUNT, wc_m);
    chk("hold_count", {16'd0, HOLD_COUNT}, {16'd0, hc_m});
    if (FIFO_WRITE && first_wr < 0) first_wr = cyc;
  endtask

  task automatic idle(input int n);
    ARB_WRITE = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [31:0] d);
    int guard;
    guard = 0;
    ARB_WRITE = 1; ARB_DATA = d;
    do begin
      tick();
      guard++;
    end while (!last_accept && guard < 200);
    if (!last_accept) chk("push_timeout", 32'd0, 32'd1);
    ARB_WRITE = 0;
  endtask

  initial begin
    int acc, n;
    // reset
    BUS_RST = 1; tick(); tick();
    BUS_RST = 0; tick();

    // stream 20 words back-to-back
    first_acc = -1; first_wr = -1;
    for (int i = 1; i <= 20; i++) push_word(i);
    idle(4);
    chk("stream_latency", first_wr - first_acc, 2);
    chk("stream_wc", WORD_COUNT, 32'd20);

    // fill to full under NEAR_FULL
    FIFO_NEAR_FULL = 1;
    acc = 0;
    ARB_WRITE = 1;
    for (int i = 0; i < 40 && ARB_READY; i++) begin
      ARB_DATA = 32'h100 + acc;
      tick();
      if (last_accept) acc++;
    end
    ARB_WRITE = 0;
    chk("fill_accepted", acc, 16);
    chk("fill_full_level", {27'd0, FILL_LEVEL}, 32'd16);
    idle(2);

    // hysteresis: 3 low, 1 high, then low until first write
    FIFO_NEAR_FULL = 0; idle(3);
    FIFO_NEAR_FULL = 1; idle(1);
    FIFO_NEAR_FULL = 0;
    n = 0;
    do begin tick(); n++; end while (!FIFO_WRITE && n < 20);
    chk("resume_delay", n, 5);
    idle(20);

    // FIFO_FULL pulse with 8 buffered words in RUN
    FIFO_FULL = 1;
    for (int i = 0; i < 8; i++) push_word(32'h200 + i);
    FIFO_FULL = 0; tick();
    FIFO_FULL = 1; idle(3);
    FIFO_FULL = 0; idle(12);

    // reset mid-operation with 10 buffered words
    FIFO_FULL = 1;
    for (int i = 0; i < 10; i++) push_word(32'h300 + i);
    BUS_RST = 1; tick();
    BUS_RST = 0; FIFO_FULL = 0; tick();
    first_wr = -1;
    push_word(32'hDEAD_BEEF);
    idle(3);
    chk("post_reset_first", FIFO_DATA, 32'hDEAD_BEEF);

    // WORD_COUNT wrap
    force dut.word_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.word_count_q;
    wc_m = 32'hFFFF_FFFF;
    push_word(32'h0000_0A5A);
    idle(3);
    chk("wc_wrap", WORD_COUNT, 32'd0);

    // CLEAR_COUNTERS coincident with a write
    push_word(32'h0000_0C1E);
    CLEAR_COUNTERS = 1; tick();
    CLEAR_COUNTERS = 0;
    chk("clear_vs_write", WORD_COUNT, 32'd0);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ARB_WRITE      = ($urandom_range(0, 3) != 0);
      ARB_DATA       = $urandom;
      FIFO_NEAR_FULL = ($urandom_range(0, 9) < 2);
      FIFO_FULL      = ($urandom_range(0, 9) < 1);
      CLEAR_COUNTERS = ($urandom_range(0, 99) < 2);
      tick();
    end
    ARB_WRITE = 0; FIFO_NEAR_FULL = 0; FIFO_FULL = 0; CLEAR_COUNTERS = 0;
    idle(30);

    // HOLD_COUNT saturation
    CLEAR_COUNTERS = 1; tick(); CLEAR_COUNTERS = 0;
    FIFO_NEAR_FULL = 1;
    push_word(32'h5A5A_0001);
    for (int i = 0; i < 65600; i++) tick();
    chk("hc_saturate", {16'd0, HOLD_COUNT}, 32'h0000_FFFF);
    FIFO_NEAR_FULL = 0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_fifo_bridge.md
# arb_fifo_bridge

Elastic buffer and throttle stage sitting directly downstream of the readout round-robin arbiter. It accepts 32-bit words from the arbiter's write port and forwards them in order, without loss, to the downstream transfer FIFO write port (SiTCP/USB). It absorbs FIFO_NEAR_FULL back-pressure with hysteresis and exports fill-level and traffic counters for the GPIO/status registers.

## Interface
Parameters:
- ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH (legal 2..8).
- RESUME_CYCLES, 4, consecutive cycles FIFO_NEAR_FULL must stay low before leaving HOLD (legal 1..255).

Ports:
- BUS_CLK  in  1  sole clock; all logic on the rising edge.
- BUS_RST  in  1  synchronous, active-high reset.
- ARB_WRITE  in  1  arbiter word valid.
- ARB_DATA  in  32  arbiter word.
- ARB_READY  out  1  bridge can accept a word this cycle; registered.
- FIFO_WRITE  out  1  write strobe to the downstream FIFO; registered.
- FIFO_DATA  out  32  word qualified by FIFO_WRITE; registered.
- FIFO_FULL  in  1  downstream full; hard stop.
- FIFO_NEAR_FULL  in  1  downstream almost full; throttles.
- CLEAR_COUNTERS  in  1  synchronous clear of WORD_COUNT and HOLD_COUNT.
- FILL_LEVEL  out  ADDR_WIDTH+1  words currently buffered (0..DEPTH).
- WORD_COUNT  out  32  words written downstream; wraps modulo 2^32.
- HOLD_COUNT  out  16  stalled cycles; saturates at 0xFFFF.

## Operation
- Push: a word transfers on every cycle with ARB_WRITE=1 and ARB_READY=1. ARB_WRITE=1 while ARB_READY=0 transfers nothing. The arbiter holds its data.
- ARB_READY is registered: next value = (count_next < DEPTH). The buffer therefore never overflows and a push is never dropped.
- Pop condition (cycle t): buffer non-empty, FIFO_FULL=0, FIFO_NEAR_FULL=0, and state RUN. On a pop, FIFO_WRITE=1 and FIFO_DATA = head word in cycle t+1. Otherwise FIFO_WRITE=0 and FIFO_DATA holds its last value.
- Throttle FSM:
  - RUN → HOLD when FIFO_NEAR_FULL=1.
  - HOLD → RUN after RESUME_CYCLES consecutive cycles with FIFO_NEAR_FULL=0. Any high cycle resets the run-length counter.
  - No pops in HOLD.
- FIFO_FULL blocks pops in any state but does not change state.
- Simultaneous push and pop: count unchanged, order preserved. A push into an empty buffer cannot pop in the same cycle.
- Circular buffer: read and write pointers are ADDR_WIDTH bits, wrapping from DEPTH-1 to 0. The count is a separate ADDR_WIDTH+1-bit register.
- FILL_LEVEL = count register.
- WORD_COUNT: +1 per FIFO_WRITE pulse.
- HOLD_COUNT: +1 per cycle with buffer non-empty and no pop; saturating.
- CLEAR_COUNTERS=1: both counters become 0 next cycle. Clear wins over a coincident increment.

## Timing
- Reset values: ARB_READY=0, FIFO_WRITE=0, FIFO_DATA=0, FILL_LEVEL=0, WORD_COUNT=0, HOLD_COUNT=0; FSM RUN, run-length counter 0.
- ARB_READY=1 on the first cycle after BUS_RST deasserts.
- Reset mid-operation discards all buffered words. The in-flight FIFO_WRITE is cleared on the same edge.
- Latency: word pushed in cycle t into an empty buffer (RUN, no stall) → stored at the end of t → popped in t+1 → FIFO_WRITE high in t+2.
- Throughput: 1 word/cycle sustained when unthrottled.
- FIFO_FULL and FIFO_NEAR_FULL are sampled in the pop cycle, so one write can land the cycle after either rises. The downstream FIFO must assert NEAR_FULL at least 2 words before FULL.
- ARB_READY falls the cycle after the push that fills the buffer to DEPTH. It rises the cycle after the first pop from a full buffer.

## Test plan
- Reset then stream: 20 words 0x00000001..0x00000014 back-to-back, no back-pressure. Required: FIFO_WRITE first high 2 cycles after the first accept; same order; WORD_COUNT=20; FILL_LEVEL ≤1 throughout; HOLD_COUNT=0.
- Fill to full: FIFO_NEAR_FULL=1 held, push until ARB_READY drops. Required: exactly 16 accepted; FILL_LEVEL=16; no FIFO_WRITE; HOLD_COUNT increments each cycle while non-empty.
- Hysteresis (RESUME_CYCLES=4), buffer full: drop NEAR_FULL 3 cycles, raise 1, drop again. Required: first FIFO_WRITE exactly 5 cycles after the final drop (4-cycle resume + 1 register stage); all 16 words in order.
- FIFO_FULL pulse of 3 cycles in RUN with 8 words buffered. Required: no FIFO_WRITE in the 3 cycles following each high sample; state stays RUN; no loss or duplication.
- Reset mid-operation with 10 buffered words. Required: all outputs at reset values next cycle; the next pushed word 0xDEADBEEF is the first word written afterward.
- Counter edge cases:
  - Required: WORD_COUNT preloaded via 2^32 writes, or forced in simulation to 0xFFFFFFFF, wraps to 0 on the next write.
  - Required: HOLD_COUNT sticks at 0xFFFF.
  - Required: CLEAR_COUNTERS coincident with a write yields 0.
